// File: rtl/seq_pkg.sv
// Shared definitions for the vector execution sequencer: opcodes, FSM state
// encoding and small opcode classification helpers.
package seq_pkg;

    localparam int ELEMS_DEF = 16;

    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_SST  = 4'b0011;
    localparam logic [3:0] OP_VLD  = 4'b0100;
    localparam logic [3:0] OP_VST  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SLH  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Opcodes that touch the data-memory port.
    function automatic logic op_is_mem(input logic [3:0] op);
        return (op == OP_VLD) || (op == OP_VST) || (op == OP_SST);
    endfunction

    // J, NOP and the undefined range 1001..1110 all have the top bit set and
    // skip the RUN phase entirely.
    function automatic logic op_skips_run(input logic [3:0] op);
        return op[3];
    endfunction

    // Opcodes whose completion never writes a register back.
    function automatic logic op_no_wb(input logic [3:0] op);
        return (op == OP_VST) || (op == OP_SST) || (op == OP_J) || (op == OP_NOP);
    endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Data-memory address generator: base + zero-extended offset + element index,
// wrapping modulo 2^AW.
module seq_addr_gen #(
    parameter int AW = 16
) (
    input  logic [AW-1:0] base,
    input  logic [5:0]    offset,
    input  logic [3:0]    idx,
    output logic [AW-1:0] addr
);

    // Plain AW-bit add; the carry out is dropped so the address wraps.
    always_comb begin
        addr = base + {{(AW-6){1'b0}}, offset} + {{(AW-4){1'b0}}, idx};
    end

endmodule

// File: rtl/vec_exec_sequencer.sv
// Multi-cycle sequencer for one decoded instruction: latches the decoded
// fields, walks the element counter, issues memory requests with ready-stall
// and emits a single write-back/done pulse at completion.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for instr_valid; fetch free to present
//   RUN     | stepping cnt 0..cycle_count (element / drain cycles)
//   WB      | one-cycle completion: done and write-back enables
module vec_exec_sequencer
    import seq_pkg::*;
#(
    parameter int ELEMS = ELEMS_DEF,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [3:0]    functype,
    input  logic [4:0]    cycle_count,
    input  logic          v_en_in,
    input  logic          s_en_in,
    input  logic [2:0]    dst_addr_in,
    input  logic [5:0]    offset_in,
    input  logic [AW-1:0] base_in,
    input  logic          mem_ready,
    output logic          busy,
    output logic          elem_valid,
    output logic [3:0]    elem_idx,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          wb_v_en,
    output logic          wb_s_en,
    output logic [2:0]    wb_addr,
    output logic          done
);

    localparam logic [5:0] ELEMS_W = 6'(ELEMS);

    state_t          state;
    logic [4:0]      cnt;
    logic [3:0]      op_q;
    logic [4:0]      cc_q;
    logic            v_en_q;
    logic            s_en_q;
    logic [2:0]      dst_q;
    logic [5:0]      off_q;
    logic [AW-1:0]   base_q;

    logic            in_run;
    logic            elem_cyc;
    logic            req_cyc;
    logic            advance;
    logic            last_step;
    logic [3:0]      idx_cur;
    logic [AW-1:0]   gen_addr;

    // Per-cycle decode of the RUN step: element vs drain cycle and whether
    // the counter may advance this cycle.
    always_comb begin
        in_run    = (state == ST_RUN);
        elem_cyc  = in_run && ({1'b0, cnt} < ELEMS_W);
        req_cyc   = elem_cyc && op_is_mem(op_q);
        advance   = !req_cyc || mem_ready;
        last_step = (cnt == cc_q);
        idx_cur   = elem_cyc ? cnt[3:0] : 4'd0;
    end

    seq_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .base   (base_q),
        .offset (off_q),
        .idx    (idx_cur),
        .addr   (gen_addr)
    );

    // Sequencer FSM: accept in IDLE, step cnt in RUN, single-cycle WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            cc_q   <= '0;
            v_en_q <= 1'b0;
            s_en_q <= 1'b0;
            dst_q  <= '0;
            off_q  <= '0;
            base_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_q   <= functype;
                        cc_q   <= cycle_count;
                        v_en_q <= v_en_in;
                        s_en_q <= s_en_in;
                        dst_q  <= dst_addr_in;
                        off_q  <= offset_in;
                        base_q <= base_in;
                        cnt    <= '0;
                        state  <= op_skips_run(functype) ? ST_WB : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        if (last_step) begin
                            state <= ST_WB;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ST_WB: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state and latched fields; everything is
    // zero outside the cycles where a value is meaningful.
    always_comb begin
        busy       = (state != ST_IDLE);
        elem_valid = elem_cyc;
        elem_idx   = idx_cur;
        mem_req    = req_cyc;
        mem_we     = req_cyc && (op_q != OP_VLD);
        mem_addr   = req_cyc ? gen_addr : '0;
        done       = (state == ST_WB);
        wb_v_en    = done && v_en_q && !op_no_wb(op_q);
        wb_s_en    = done && s_en_q && !op_no_wb(op_q);
        wb_addr    = (done && !op_no_wb(op_q)) ? dst_q : 3'd0;
    end

endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Scoreboard bench for vec_exec_sequencer: each scenario pushes the expected
// per-cycle output picture when it issues an instruction; a negedge monitor
// pops and compares every cycle and supplies mem_ready from the same entry.
module tb_vec_exec_sequencer;

    typedef struct packed {
        logic        rdy;
        logic        busy;
        logic        ev;
        logic [3:0]  idx;
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic        wbv;
        logic        wbs;
        logic [2:0]  wba;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [3:0]  functype = '0;
    logic [4:0]  cycle_count = '0;
    logic        v_en_in = 1'b0;
    logic        s_en_in = 1'b0;
    logic [2:0]  dst_addr_in = '0;
    logic [5:0]  offset_in = '0;
    logic [15:0] base_in = '0;
    logic        mem_ready = 1'b1;
    logic        busy;
    logic        elem_valid;
    logic [3:0]  elem_idx;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        wb_v_en;
    logic        wb_s_en;
    logic [2:0]  wb_addr;
    logic        done;

    int    checks = 0;
    int    errors = 0;
    string cur_test = "init";
    exp_t  q[$];

    vec_exec_sequencer #(
        .ELEMS (16),
        .AW    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .functype    (functype),
        .cycle_count (cycle_count),
        .v_en_in     (v_en_in),
        .s_en_in     (s_en_in),
        .dst_addr_in (dst_addr_in),
        .offset_in   (offset_in),
        .base_in     (base_in),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .elem_valid  (elem_valid),
        .elem_idx    (elem_idx),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .wb_v_en     (wb_v_en),
        .wb_s_en     (wb_s_en),
        .wb_addr     (wb_addr),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t sample(input logic rdy);
        exp_t o;
        o.rdy  = rdy;
        o.busy = busy;
        o.ev   = elem_valid;
        o.idx  = elem_idx;
        o.req  = mem_req;
        o.we   = mem_we;
        o.addr = mem_addr;
        o.wbv  = wb_v_en;
        o.wbs  = wb_s_en;
        o.wba  = wb_addr;
        o.done = done;
        return o;
    endfunction

    // Scoreboard consumer: one expected entry per clock cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t obs;
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            mem_ready = e.rdy;
            obs = sample(e.rdy);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cycle: got %h want %h", cur_test, obs, e);
            end
        end else begin
            mem_ready = 1'b1;
        end
    end

    // Reference model: expected cycle sequence from the accept edge through
    // the first IDLE cycle after completion.
    task automatic push_model(input logic [3:0] op, input logic [4:0] cc,
                              input logic v, input logic s, input logic [2:0] dst,
                              input logic [5:0] off, input logic [15:0] base,
                              input int stall_idx, input int stall_n);
        exp_t e;
        logic is_mem;
        logic no_wb;
        is_mem = (op == 4'h3) || (op == 4'h4) || (op == 4'h5);
        no_wb  = (op == 4'h3) || (op == 4'h5) || (op == 4'h8) || (op == 4'hF);
        if (op < 4'h8) begin
            for (int c = 0; c <= int'(cc); c++) begin
                e = '0;
                e.busy = 1'b1;
                if (c < 16) begin
                    e.ev  = 1'b1;
                    e.idx = 4'(c);
                    if (is_mem) begin
                        e.req  = 1'b1;
                        e.we   = (op != 4'h4);
                        e.addr = base + {10'd0, off} + 16'(c);
                    end
                end
                if (e.req && c == stall_idx) begin
                    for (int k = 0; k < stall_n; k++) begin
                        e.rdy = 1'b0;
                        q.push_back(e);
                    end
                end
                e.rdy = 1'b1;
                q.push_back(e);
            end
        end
        e = '0;
        e.rdy  = 1'b1;
        e.busy = 1'b1;
        e.done = 1'b1;
        e.wbv  = v && !no_wb;
        e.wbs  = s && !no_wb;
        e.wba  = no_wb ? 3'd0 : dst;
        q.push_back(e);
        e = '0;
        e.rdy = 1'b1;
        q.push_back(e);
    endtask

    task automatic drive_fields(input logic [3:0] op, input logic [4:0] cc,
                                input logic v, input logic s, input logic [2:0] dst,
                                input logic [5:0] off, input logic [15:0] base);
        functype    = op;
        cycle_count = cc;
        v_en_in     = v;
        s_en_in     = s;
        dst_addr_in = dst;
        offset_in   = off;
        base_in     = base;
    endtask

    // Present one instruction for a single cycle from IDLE and queue its model.
    task automatic issue(input logic [3:0] op, input logic [4:0] cc,
                         input logic v, input logic s, input logic [2:0] dst,
                         input logic [5:0] off, input logic [15:0] base,
                         input int stall_idx, input int stall_n);
        @(posedge clk);
        #1;
        drive_fields(op, cc, v, s, dst, off, base);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        push_model(op, cc, v, s, dst, off, base, stall_idx, stall_n);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d entries left want 0", cur_test, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        exp_t obs;
        cur_test = "reset";
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs = sample(1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        rst = 1'b0;
        @(negedge clk);
        obs = sample(1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h want 0", obs);
        end
    endtask

    task automatic test_vadd();
        cur_test = "vadd";
        issue(4'h0, 5'd15, 1'b1, 1'b0, 3'd3, 6'd0, 16'h0000, -1, 0);
        wait_drain();
    endtask

    task automatic test_vld();
        cur_test = "vld";
        issue(4'h4, 5'd16, 1'b1, 1'b0, 3'd5, 6'd4, 16'h0100, -1, 0);
        wait_drain();
    endtask

    task automatic test_vst_stall();
        cur_test = "vst_stall";
        issue(4'h5, 5'd15, 1'b1, 1'b1, 3'd6, 6'd1, 16'h0200, 5, 3);
        wait_drain();
    endtask

    task automatic test_vst_wrap();
        cur_test = "vst_wrap";
        issue(4'h5, 5'd15, 1'b0, 1'b0, 3'd0, 6'd0, 16'hFFFE, -1, 0);
        wait_drain();
    endtask

    task automatic test_sst_stall();
        cur_test = "sst_stall";
        issue(4'h3, 5'd0, 1'b0, 1'b1, 3'd1, 6'd2, 16'h1234, 0, 2);
        wait_drain();
    endtask

    // SLL, NOP, J with instr_valid held high throughout; fields change while
    // busy and must only be taken in IDLE.
    task automatic test_back_to_back();
        cur_test = "back_to_back";
        @(posedge clk);
        #1;
        drive_fields(4'h6, 5'd0, 1'b0, 1'b1, 3'd2, 6'd0, 16'h0000);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        drive_fields(4'hF, 5'd0, 1'b1, 1'b1, 3'd7, 6'd0, 16'h0000);
        push_model(4'h6, 5'd0, 1'b0, 1'b1, 3'd2, 6'd0, 16'h0000, -1, 0);
        push_model(4'hF, 5'd0, 1'b1, 1'b1, 3'd7, 6'd0, 16'h0000, -1, 0);
        push_model(4'h8, 5'd0, 1'b1, 1'b1, 3'd4, 6'd0, 16'h0000, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        drive_fields(4'h8, 5'd0, 1'b1, 1'b1, 3'd4, 6'd0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_async_reset();
        exp_t obs;
        cur_test = "async_reset";
        issue(4'h1, 5'd15, 1'b1, 1'b0, 3'd4, 6'd0, 16'h0000, -1, 0);
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        obs = sample(1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h want 0", obs);
        end
        @(negedge clk);
        obs = sample(1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_hold: got %h want 0", obs);
        end
        rst = 1'b0;
        cur_test = "vdot_restart";
        issue(4'h1, 5'd15, 1'b1, 1'b0, 3'd6, 6'd0, 16'h0000, -1, 0);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_vadd();
        test_vld();
        test_vst_stall();
        test_vst_wrap();
        test_sst_stall();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
